// File: rtl/bus_source_arbiter_if.sv
// rtl/bus_source_arbiter_if.sv - shared bus request/grant interface for bus_source_arbiter
interface bus_source_arbiter_if #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 2
);
  logic                      enable;
  logic [CHANNELS-1:0]       req;
  logic                      lock;
  logic [CHANNELS*WIDTH-1:0] data_in;
  logic [CHANNELS-1:0]       grant;
  logic [WIDTH-1:0]          out_bits;
  logic                      valid;

  // Requesters and controller side
  modport master (
    output enable, req, lock, data_in,
    input  grant, out_bits, valid
  );

  // Arbiter side
  modport slave (
    input  enable, req, lock, data_in,
    output grant, out_bits, valid
  );
endinterface

// File: rtl/bus_source_arbiter.sv
// rtl/bus_source_arbiter.sv - registered round-robin / fixed-priority bus source arbiter with lock
module bus_source_arbiter #(
  parameter int WIDTH         = 4,
  parameter int CHANNELS      = 2,
  parameter int PRIORITY_MODE = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  bus_source_arbiter_if.slave  bus
);

  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANTED = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  // Pointer starts at the last channel so the first round-robin scan begins at channel 0
  localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(CHANNELS - 1);

  logic [1:0]          state_q,    state_d;
  logic [IDX_W-1:0]    last_q,     last_d;
  logic [CHANNELS-1:0] grant_q,    grant_d;
  logic [WIDTH-1:0]    out_bits_q, out_bits_d;
  logic                valid_q,    valid_d;

  logic [WIDTH-1:0]    src [CHANNELS];
  logic                pick_found;
  logic [IDX_W-1:0]    pick_idx;
  logic                hold_lock;

  // Unpack the flat source bus into one word per channel
  for (genvar c = 0; c < CHANNELS; c++) begin : g_src
    assign src[c] = bus.data_in[c*WIDTH +: WIDTH];
  end

  // Select the winning requester for this cycle
  always_comb begin
    int scan_i;
    logic [IDX_W-1:0] scan_idx;
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_i     = 0;
    scan_idx   = '0;
    if (PRIORITY_MODE != 0) begin
      // Walk from the top down so the lowest set index is the last one written
      for (int i = CHANNELS - 1; i >= 0; i--) begin
        if (bus.req[IDX_W'(i)]) begin
          pick_found = 1'b1;
          pick_idx   = IDX_W'(i);
        end
      end
    end else begin
      // Scan last+1 .. last+CHANNELS with wrap; the previous winner is checked last
      for (int i = 1; i <= CHANNELS; i++) begin
        scan_i   = (int'(last_q) + i) % CHANNELS;
        scan_idx = IDX_W'(scan_i);
        if (!pick_found && bus.req[scan_idx]) begin
          pick_found = 1'b1;
          pick_idx   = scan_idx;
        end
      end
    end
  end

  // A held lock keeps the current owner as long as it keeps requesting
  assign hold_lock = (state_q == ST_LOCKED) && bus.lock && bus.req[last_q];

  // Next-state, pointer and output register computation
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    grant_d    = grant_q;
    out_bits_d = out_bits_q;
    valid_d    = valid_q;
    if (bus.enable) begin
      if (hold_lock) begin
        out_bits_d = src[last_q];
      end else if (pick_found) begin
        last_d     = pick_idx;
        grant_d    = CHANNELS'(1) << pick_idx;
        out_bits_d = src[pick_idx];
        valid_d    = 1'b1;
        state_d    = bus.lock ? ST_LOCKED : ST_GRANTED;
      end else begin
        // Idle: drop grant and valid, leave the last bus value in place
        grant_d = '0;
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    end
  end

  // State and output registers; reset takes precedence over enable
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      last_q     <= LAST_RESET;
      grant_q    <= '0;
      out_bits_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      out_bits_q <= out_bits_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.out_bits = out_bits_q;
  assign bus.valid    = valid_q;

endmodule

// File: tb/tb_bus_source_arbiter.sv
// tb/tb_bus_source_arbiter.sv - vector table plus scoreboard bench for bus_source_arbiter
module tb_bus_source_arbiter;

  typedef struct {
    string      name;
    bit         rst;
    bit         en;
    logic [1:0] req;
    bit         lk;
    logic [7:0] din;
    logic [1:0] g;
    logic [3:0] ob;
    bit         v;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_cmp = 0;
  int n_err = 0;

  vec_t tbl[$];
  vec_t sb[$];

  bus_source_arbiter_if #(.WIDTH(4), .CHANNELS(2)) bus_rr ();
  bus_source_arbiter_if #(.WIDTH(4), .CHANNELS(2)) bus_fp ();

  bus_source_arbiter #(.WIDTH(4), .CHANNELS(2), .PRIORITY_MODE(0)) dut_rr (
    .clk   (clk),
    .reset (rst),
    .bus   (bus_rr)
  );

  bus_source_arbiter #(.WIDTH(4), .CHANNELS(2), .PRIORITY_MODE(1)) dut_fp (
    .clk   (clk),
    .reset (rst),
    .bus   (bus_fp)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(string n, bit r, bit e, logic [1:0] rq, bit lk,
                              logic [7:0] d, logic [1:0] g, logic [3:0] ob, bit v);
    vec_t t;
    t.name = n; t.rst = r; t.en = e; t.req = rq; t.lk = lk;
    t.din = d; t.g = g; t.ob = ob; t.v = v;
    return t;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one vector into both DUTs, queue its expectation, compare after the edge
  task automatic apply(vec_t t, bit use_fp);
    vec_t e;
    logic [1:0] g;
    logic [3:0] ob;
    logic       v;
    @(negedge clk);
    rst            = t.rst;
    bus_rr.enable  = t.en;   bus_fp.enable  = t.en;
    bus_rr.req     = t.req;  bus_fp.req     = t.req;
    bus_rr.lock    = t.lk;   bus_fp.lock    = t.lk;
    bus_rr.data_in = t.din;  bus_fp.data_in = t.din;
    sb.push_back(t);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (use_fp) begin
      g = bus_fp.grant; ob = bus_fp.out_bits; v = bus_fp.valid;
    end else begin
      g = bus_rr.grant; ob = bus_rr.out_bits; v = bus_rr.valid;
    end
    check({e.name, " grant"},    32'(g),  32'(e.g));
    check({e.name, " out_bits"}, 32'(ob), 32'(e.ob));
    check({e.name, " valid"},    32'(v),  32'(e.v));
    check({e.name, " onehot0"},  32'($onehot0(g)), 32'(1));
    check({e.name, " valid_eq"}, 32'(v),  32'(|g));
  endtask

  initial begin
    bus_rr.enable = 1'b1; bus_rr.req = '0; bus_rr.lock = 1'b0; bus_rr.data_in = '0;
    bus_fp.enable = 1'b1; bus_fp.req = '0; bus_fp.lock = 1'b0; bus_fp.data_in = '0;

    // name, rst, en, req, lock, data_in{ch1,ch0}, grant, out_bits, valid
    tbl.push_back(mk("reset0",      1, 1, 2'b11, 0, 8'h7F, 2'b00, 4'h0, 0));
    tbl.push_back(mk("reset1",      1, 1, 2'b11, 0, 8'h7F, 2'b00, 4'h0, 0));
    tbl.push_back(mk("first_grant", 0, 1, 2'b11, 0, 8'h7F, 2'b01, 4'hF, 1));
    tbl.push_back(mk("sel_ch0",     0, 1, 2'b01, 0, 8'h7F, 2'b01, 4'hF, 1));
    tbl.push_back(mk("sel_ch1",     0, 1, 2'b10, 0, 8'h7F, 2'b10, 4'h7, 1));
    tbl.push_back(mk("rr0",         0, 1, 2'b11, 0, 8'h7F, 2'b01, 4'hF, 1));
    tbl.push_back(mk("rr1",         0, 1, 2'b11, 0, 8'h7F, 2'b10, 4'h7, 1));
    tbl.push_back(mk("rr2",         0, 1, 2'b11, 0, 8'h7F, 2'b01, 4'hF, 1));
    tbl.push_back(mk("rr3",         0, 1, 2'b11, 0, 8'h7F, 2'b10, 4'h7, 1));
    tbl.push_back(mk("lock0",       0, 1, 2'b11, 1, 8'h73, 2'b01, 4'h3, 1));
    tbl.push_back(mk("lock1",       0, 1, 2'b11, 1, 8'h74, 2'b01, 4'h4, 1));
    tbl.push_back(mk("lock2",       0, 1, 2'b11, 1, 8'h75, 2'b01, 4'h5, 1));
    tbl.push_back(mk("unlock",      0, 1, 2'b11, 0, 8'h75, 2'b10, 4'h7, 1));
    tbl.push_back(mk("en_hold0",    0, 0, 2'b01, 0, 8'h12, 2'b10, 4'h7, 1));
    tbl.push_back(mk("en_hold1",    0, 0, 2'b00, 0, 8'h34, 2'b10, 4'h7, 1));
    tbl.push_back(mk("en_hold2",    0, 0, 2'b11, 1, 8'hAB, 2'b10, 4'h7, 1));
    tbl.push_back(mk("en_resume",   0, 1, 2'b11, 0, 8'h7F, 2'b01, 4'hF, 1));
    tbl.push_back(mk("idle0",       0, 1, 2'b00, 0, 8'h7F, 2'b00, 4'hF, 0));
    tbl.push_back(mk("idle1",       0, 1, 2'b00, 0, 8'h12, 2'b00, 4'hF, 0));
    tbl.push_back(mk("from_idle",   0, 1, 2'b10, 0, 8'h7F, 2'b10, 4'h7, 1));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], 1'b0);

    // Reset while LOCKED must not carry the lock over
    apply(mk("mid_lock",     0, 1, 2'b11, 1, 8'h7F, 2'b01, 4'hF, 1), 1'b0);
    apply(mk("mid_reset",    1, 1, 2'b11, 1, 8'h7F, 2'b00, 4'h0, 0), 1'b0);
    apply(mk("post_reset",   0, 1, 2'b11, 1, 8'h7F, 2'b01, 4'hF, 1), 1'b0);
    apply(mk("relock_track", 0, 1, 2'b11, 1, 8'h7E, 2'b01, 4'hE, 1), 1'b0);
    // Owner drops its request while lock stays high: re-arbitrate and lock the new owner
    apply(mk("owner_drop",   0, 1, 2'b10, 1, 8'h7F, 2'b10, 4'h7, 1), 1'b0);
    apply(mk("new_owner",    0, 1, 2'b10, 1, 8'h6E, 2'b10, 4'h6, 1), 1'b0);
    // Reset wins over enable=0, and enable=0 then holds the reset values
    apply(mk("rst_over_en",  1, 0, 2'b11, 0, 8'h7F, 2'b00, 4'h0, 0), 1'b0);
    apply(mk("en_off_rst",   0, 0, 2'b11, 0, 8'h7F, 2'b00, 4'h0, 0), 1'b0);

    // Fixed-priority instance: lowest index always wins
    apply(mk("fp_reset",     1, 1, 2'b11, 0, 8'h7F, 2'b00, 4'h0, 0), 1'b1);
    apply(mk("fp0",          0, 1, 2'b11, 0, 8'h7F, 2'b01, 4'hF, 1), 1'b1);
    apply(mk("fp1",          0, 1, 2'b11, 0, 8'h7F, 2'b01, 4'hF, 1), 1'b1);
    apply(mk("fp2",          0, 1, 2'b11, 0, 8'h7F, 2'b01, 4'hF, 1), 1'b1);
    apply(mk("fp_only1",     0, 1, 2'b10, 0, 8'h7F, 2'b10, 4'h7, 1), 1'b1);
    apply(mk("fp_back0",     0, 1, 2'b11, 0, 8'h7F, 2'b01, 4'hF, 1), 1'b1);

    check("scoreboard_empty", 32'(sb.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
